dm_trace_ctrl: RTL
==================

Name: dm_trace_ctrl

Overview:
Synthesizable run controller and data-memory write tracer for processor_arm bring-up.
- Sequences the processor reset, then runs for a programmable number of cycles.
- Captures every data-memory write (DM_addr, DM_writeData) into a DEPTH-entry circular buffer.
- On run end or external request, raises dump and streams the captured writes oldest-first over a valid/ready port.
- Sits between processor_arm and the bench or host readout logic. It is the parametrised, hardware replacement for the fixed reset/dump sequencing.

Parameters:
- N, 64, width of DM_addr, DM_writeData, trace_addr and trace_data.
- DEPTH, 16, number of trace entries; power of two, ≥2.
- RESET_CYCLES, 2, cycles cpu_reset is held after reset deassertion; ≥1.
- RUN_CYCLES, 60, cycles spent in RUN before an automatic dump; ≥1.
- WRAP, 1, buffer-full policy: 1 = overwrite oldest entry; 0 = drop new writes.

Ports:
- CLOCK_50, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-high reset of the whole block.
- DM_writeEnable, in, 1, processor data-memory write strobe.
- DM_addr, in, N, processor data-memory address.
- DM_writeData, in, N, processor data-memory write data.
- dump_req, in, 1, early dump request, honoured in RUN only.
- cpu_reset, out, 1, reset driven to processor_arm.
- dump, out, 1, high from DUMP entry onward; processor-side dump trigger.
- trace_valid, out, 1, trace entry presented.
- trace_ready, in, 1, consumer accepts the entry.
- trace_addr, out, N, address of the presented entry.
- trace_data, out, N, data of the presented entry.
- trace_count, out, $clog2(DEPTH)+1, entries currently held.
- overflow, out, 1, sticky: at least one write was lost or overwritten.
- done, out, 1, trace fully drained.

Behaviour:
- Async reset values:
  - State HOLD, cpu_reset=1.
  - dump=0, trace_valid=0, trace_addr=0, trace_data=0.
  - trace_count=0, overflow=0, done=0.
  - All pointers and counters 0.
- FSM states: HOLD, RUN, DUMP, DONE. All outputs are registered or decoded from registered state.
- HOLD:
  - cpu_reset=1; counts RESET_CYCLES clock edges after reset falls.
  - Moves to RUN on the edge where the count reaches RESET_CYCLES-1.
  - cpu_reset goes low in the first RUN cycle.
- RUN:
  - Capture: on each edge with DM_writeEnable=1, push {DM_addr, DM_writeData} at wr_ptr, wr_ptr++ (mod DEPTH), trace_count++.
  - Full buffer, WRAP=1: write at wr_ptr, advance both wr_ptr and rd_ptr, count unchanged, overflow←1.
  - Full buffer, WRAP=0: discard the write, overflow←1.
  - Cycle counter runs from 0. Go to DUMP after RUN_CYCLES RUN cycles, or on the edge with dump_req=1, whichever comes first.
  - A write present on the transitioning edge is still captured.
- DUMP:
  - dump=1. trace_valid=1 while trace_count>0.
  - trace_addr/trace_data = entry at rd_ptr; both forced to 0 when trace_valid=0.
  - Handshake: an entry transfers on an edge with trace_valid & trace_ready; then rd_ptr++ (mod DEPTH) and trace_count--.
  - trace_valid, addr and data stay stable while trace_ready=0.
  - DM_writeEnable and dump_req are ignored.
  - When trace_count=0 at the start of a cycle (including entering with an empty buffer), go to DONE next edge; trace_valid is never asserted for an empty buffer.
- DONE: dump=1, done=1, trace_valid=0. The block stays in DONE until reset.
- Pointer wrap: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally. trace_count saturates at DEPTH.
- overflow is sticky; only reset clears it.
- Reset mid-operation (any state): immediate return to reset values; the buffer contents are logically discarded (count=0).
- cpu_reset stays low in RUN, DUMP and DONE.

Test Plan:
1. reset high 2 cycles then low, RESET_CYCLES=2 → cpu_reset high for exactly 2 edges after reset fall, low in the first RUN cycle; dump=0.
2. RUN_CYCLES=60, writes (0x10,0xAA),(0x18,0xBB),(0x20,0xCC), trace_ready=1 → dump rises after 60 RUN cycles; trace emits 0x10/0xAA, 0x18/0xBB, 0x20/0xCC on consecutive cycles; done=1 the cycle after count hits 0.
3. DEPTH=4, WRAP=1, 6 writes with addr 0..5 (data=addr) → overflow=1, trace_count=4, drained addrs 2,3,4,5.
4. DEPTH=4, WRAP=0, same 6 writes → overflow=1, drained addrs 0,1,2,3.
5. dump_req pulse at RUN cycle 5, trace_ready toggling 1,0,0,1 → DUMP entered at cycle 5; the entry holds stable through the ready-low cycles; no entry duplicated or skipped.
6. reset asserted mid-DUMP with 2 entries left → outputs return to reset values asynchronously; after release, the HOLD→RUN sequence repeats with trace_count=0 and overflow=0.

Source files
------------

// File: rtl/dm_trace_ctrl.sv
// dm_trace_ctrl: sequences the processor reset and run window, traces data-memory writes
// into a circular buffer, then streams them oldest-first over a valid/ready port.
module dm_trace_ctrl #(
    parameter int N            = 64,
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 60,
    parameter int WRAP         = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       DM_writeEnable,
    input  logic [N-1:0]               DM_addr,
    input  logic [N-1:0]               DM_writeData,
    input  logic                       dump_req,
    output logic                       cpu_reset,
    output logic                       dump,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [N-1:0]               trace_addr,
    output logic [N-1:0]               trace_data,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic                       overflow,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {HOLD, RUN, DUMP, DONE} state_t;

    state_t         r_state;
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [AW:0]    r_count;
    logic [31:0]    r_cyc;
    logic           r_overflow;
    logic [2*N-1:0] r_mem [DEPTH];

    logic           w_push, w_full, w_store;
    logic [2*N-1:0] w_entry;

    assign w_push  = (r_state == RUN) && DM_writeEnable;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_store = w_push && (!w_full || WRAP != 0);
    assign w_entry = r_mem[r_rd_ptr];

    assign cpu_reset   = r_state == HOLD;
    assign dump        = (r_state == DUMP) || (r_state == DONE);
    assign done        = r_state == DONE;
    assign trace_valid = (r_state == DUMP) && (r_count != '0);
    assign trace_addr  = trace_valid ? w_entry[2*N-1:N] : '0;
    assign trace_data  = trace_valid ? w_entry[N-1:0] : '0;
    assign trace_count = r_count;
    assign overflow    = r_overflow;

    // Storage needs no reset: an empty count makes stale contents unreachable.
    always_ff @(posedge CLOCK_50) begin
        if (w_store)
            r_mem[r_wr_ptr] <= {DM_addr, DM_writeData};
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= HOLD;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cyc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cyc == 32'(RESET_CYCLES - 1)) begin
                        r_state <= RUN;
                        r_cyc   <= '0;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                RUN: begin
                    if (w_push && !w_full) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_count  <= r_count + 1'b1;
                    end else if (w_push) begin
                        r_overflow <= 1'b1;
                        // Overwriting the oldest entry drags the read pointer along.
                        if (WRAP != 0) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                    if (dump_req || r_cyc == 32'(RUN_CYCLES - 1))
                        r_state <= DUMP;
                    else
                        r_cyc <= r_cyc + 32'd1;
                end
                DUMP: begin
                    if (r_count == '0) begin
                        r_state <= DONE;
                    end else if (trace_ready) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_count  <= r_count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
